// File: rtl/multicycle_divider.sv
// Sequential sign-magnitude divider: restoring shift-subtract, one quotient bit per clock.
// Results are truncated toward zero and are never negative zero.
module multicycle_divider #(
  parameter int OPERAND_WIDTH_IN_BITS = 64
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             is_valid_in,
  output logic                             is_ready_out,
  output logic                             is_valid_out,
  input  logic                             dividend_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_in,
  input  logic                             divisor_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
  output logic                             quotient_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] quotient_out,
  output logic                             remainder_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] remainder_out
);

  // state | meaning
  // IDLE  | ready; latches operands on valid request
  // BUSY  | one shift-subtract iteration per cycle, W iterations
  // DONE  | publishes results and raises the one-cycle valid pulse

  localparam int W  = OPERAND_WIDTH_IN_BITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic            dend_sign_q, dend_sign_d;
  logic            dvs_sign_q, dvs_sign_d;
  logic            valid_q, valid_d;
  logic            q_sign_q, q_sign_d;
  logic [W-1:0]    q_mag_q, q_mag_d;
  logic            r_sign_q, r_sign_d;
  logic [W-1:0]    r_mag_q, r_mag_d;

  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic            fits;

  // The shifted partial remainder can exceed W bits, so compare/subtract at W+1.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dend_sign_d = dend_sign_q;
    dvs_sign_d  = dvs_sign_q;
    valid_d     = 1'b0;
    q_sign_d    = q_sign_q;
    q_mag_d     = q_mag_q;
    r_sign_d    = r_sign_q;
    r_mag_d     = r_mag_q;
    case (state_q)
      IDLE: begin
        if (is_valid_in) begin
          quo_d       = dividend_in;
          dvs_d       = divisor_in;
          dend_sign_d = dividend_sign_in;
          dvs_sign_d  = divisor_sign_in;
          rem_d       = '0;
          cnt_d       = CW'(W);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        quo_d = {quo_q[W-2:0], fits};
        rem_d = fits ? diff[W-1:0] : shifted[W-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        valid_d  = 1'b1;
        q_mag_d  = quo_q;
        r_mag_d  = rem_q;
        q_sign_d = (quo_q != '0) & (dend_sign_q ^ dvs_sign_q);
        r_sign_d = (rem_q != '0) & dend_sign_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dend_sign_q <= 1'b0;
      dvs_sign_q  <= 1'b0;
      valid_q     <= 1'b0;
      q_sign_q    <= 1'b0;
      q_mag_q     <= '0;
      r_sign_q    <= 1'b0;
      r_mag_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dend_sign_q <= dend_sign_d;
      dvs_sign_q  <= dvs_sign_d;
      valid_q     <= valid_d;
      q_sign_q    <= q_sign_d;
      q_mag_q     <= q_mag_d;
      r_sign_q    <= r_sign_d;
      r_mag_q     <= r_mag_d;
    end
  end

  assign is_ready_out       = (state_q == IDLE);
  assign is_valid_out       = valid_q;
  assign quotient_sign_out  = q_sign_q;
  assign quotient_out       = q_mag_q;
  assign remainder_sign_out = r_sign_q;
  assign remainder_out      = r_mag_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Bench for multicycle_divider: directed and random divides checked against
// a plain-arithmetic sign-magnitude reference.
module tb_multicycle_divider;
  localparam int W = 64;

  logic         clk_in = 1'b0;
  logic         reset_in = 1'b1;
  logic         is_valid_in = 1'b0;
  logic         is_ready_out, is_valid_out;
  logic         dividend_sign_in = 1'b0, divisor_sign_in = 1'b0;
  logic [W-1:0] dividend_in = '0, divisor_in = '0;
  logic         quotient_sign_out, remainder_sign_out;
  logic [W-1:0] quotient_out, remainder_out;

  int errors = 0;
  int checks = 0;

  multicycle_divider #(.OPERAND_WIDTH_IN_BITS(W)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .is_valid_in(is_valid_in), .is_ready_out(is_ready_out), .is_valid_out(is_valid_out),
    .dividend_sign_in(dividend_sign_in), .dividend_in(dividend_in),
    .divisor_sign_in(divisor_sign_in), .divisor_in(divisor_in),
    .quotient_sign_out(quotient_sign_out), .quotient_out(quotient_out),
    .remainder_sign_out(remainder_sign_out), .remainder_out(remainder_out)
  );

  initial forever #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic ref_div(input logic ds, input logic [W-1:0] dd, input logic vs,
                         input logic [W-1:0] dv, output logic qs, output logic [W-1:0] q,
                         output logic rs, output logic [W-1:0] r);
    if (dv == 0) begin
      q = '1;
      r = dd;
    end else begin
      q = dd / dv;
      r = dd % dv;
    end
    qs = (q != 0) ? (ds ^ vs) : 1'b0;
    rs = (r != 0) ? ds : 1'b0;
  endtask

  task automatic scramble_inputs();
    dividend_sign_in = 1'($urandom());
    divisor_sign_in  = 1'($urandom());
    dividend_in      = rnd64();
    divisor_in       = rnd64();
  endtask

  // Starts and ends #1 after a rising edge; hold = extra cycles is_valid_in stays high.
  task automatic run_div(input string name, input logic ds, input logic [W-1:0] dd,
                         input logic vs, input logic [W-1:0] dv, input int hold,
                         input bit chk_hold);
    logic eqs, ers;
    logic [W-1:0] eq, er;
    int cyc;
    int pulses;
    ref_div(ds, dd, vs, dv, eqs, eq, ers, er);
    dividend_sign_in = ds; dividend_in = dd;
    divisor_sign_in  = vs; divisor_in  = dv;
    is_valid_in = 1'b1;
    checks++;
    if (is_ready_out !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b expected 1", name, is_ready_out);
    end
    @(posedge clk_in); #1;
    cyc = 0;
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(posedge clk_in); #1;
      cyc++;
    end
    is_valid_in = 1'b0;
    scramble_inputs();
    checks++;
    if (is_ready_out !== 1'b0) begin
      errors++; $display("FAIL %s ready_busy: got %b expected 0", name, is_ready_out);
    end
    pulses = 0;
    while (is_valid_out !== 1'b1 && cyc < 4 * W) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    checks++;
    if (cyc != W + 1) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, W + 1);
      return;
    end
    checks++;
    if (quotient_out !== eq || quotient_sign_out !== eqs) begin
      errors++; $display("FAIL %s quotient: got %b/%h expected %b/%h", name,
                         quotient_sign_out, quotient_out, eqs, eq);
    end
    checks++;
    if (remainder_out !== er || remainder_sign_out !== ers) begin
      errors++; $display("FAIL %s remainder: got %b/%h expected %b/%h", name,
                         remainder_sign_out, remainder_out, ers, er);
    end
    checks++;
    if (is_ready_out !== 1'b1) begin
      errors++; $display("FAIL %s ready_after: got %b expected 1", name, is_ready_out);
    end
    if (chk_hold) begin
      @(posedge clk_in); #1;
      checks++;
      if (is_valid_out !== 1'b0 || quotient_out !== eq || remainder_out !== er) begin
        errors++; $display("FAIL %s hold: valid=%b q=%h r=%h expected valid=0 q=%h r=%h",
                           name, is_valid_out, quotient_out, remainder_out, eq, er);
      end
      // A held request must not spawn a second operation.
      for (int i = 0; i < W + 8; i++) begin
        @(posedge clk_in); #1;
        if (is_valid_out === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
        errors++; $display("FAIL %s extra_pulse: got %0d expected 0", name, pulses);
      end
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    is_valid_in = 1'b1;
    scramble_inputs();
    repeat (3) @(posedge clk_in);
    #1;
    is_valid_in = 1'b0;
    reset_in = 1'b0;
    checks++;
    if (is_ready_out !== 1'b1 || is_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: ready=%b valid=%b expected 1 0",
                         is_ready_out, is_valid_out);
    end
    checks++;
    if (quotient_out !== '0 || remainder_out !== '0 || quotient_sign_out !== 1'b0 ||
        remainder_sign_out !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: q=%b/%h r=%b/%h expected all 0",
                         quotient_sign_out, quotient_out, remainder_sign_out, remainder_out);
    end
  endtask

  task automatic test_directed();
    run_div("p7_p2", 1'b0, 64'd7, 1'b0, 64'd2, 0, 1'b1);
    checks++;
    if (quotient_out !== 64'd3 || remainder_out !== 64'd1 ||
        quotient_sign_out !== 1'b0 || remainder_sign_out !== 1'b0) begin
      errors++; $display("FAIL p7_p2_const: got q=%h r=%h expected q=3 r=1",
                         quotient_out, remainder_out);
    end
    run_div("n7_p2", 1'b1, 64'd7, 1'b0, 64'd2, 0, 1'b1);
    run_div("p7_n2", 1'b0, 64'd7, 1'b1, 64'd2, 0, 1'b1);
    run_div("big_neg", 1'b1, {W{1'b1}}, 1'b1, 64'h7FFF_FFFF_FFFF_FFFE, 0, 1'b1);
    checks++;
    if (quotient_out !== 64'd2 || remainder_out !== 64'd3 ||
        quotient_sign_out !== 1'b0 || remainder_sign_out !== 1'b1) begin
      errors++; $display("FAIL big_neg_const: got q=%b/%h r=%b/%h expected 0/2 1/3",
                         quotient_sign_out, quotient_out, remainder_sign_out, remainder_out);
    end
    run_div("max_max", 1'b0, {W{1'b1}}, 1'b0, {W{1'b1}}, 0, 1'b0);
    run_div("wide_cmp", 1'b0, {W{1'b1}}, 1'b1, 64'h8000_0000_0000_0001, 0, 1'b0);
    run_div("zero_rem", 1'b1, 64'd6, 1'b0, 64'd3, 0, 1'b0);
    run_div("small_dend", 1'b1, 64'd1, 1'b1, 64'd5, 0, 1'b0);
    run_div("zero_dend", 1'b1, 64'd0, 1'b0, 64'd9, 0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_div("x_div_0", 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 0, 1'b0);
    checks++;
    if (quotient_out !== {W{1'b1}} || remainder_out !== 64'h1234_5678_9ABC_DEF0) begin
      errors++; $display("FAIL x_div_0_const: got q=%h r=%h expected q=all ones r=dividend",
                         quotient_out, remainder_out);
    end
    run_div("x_div_0b", 1'b0, rnd64(), 1'b1, 64'd0, 0, 1'b0);
  endtask

  task automatic test_held_valid();
    run_div("held_valid", 1'b0, 64'd1000, 1'b1, 64'd7, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_div("b2b_0", 1'b0, rnd64(), 1'b0, 64'd13, 0, 1'b0);
    run_div("b2b_1", 1'b1, rnd64(), 1'b0, rnd64() >> 20, 0, 1'b0);
    run_div("b2b_2", 1'b0, rnd64(), 1'b1, rnd64(), 0, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] dd, dv;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: begin dd = rnd64(); dv = rnd64() >> $urandom_range(0, 62); end
        1: begin dd = rnd64(); dv = W'($urandom_range(1, 65535)); end
        2: begin dd = rnd64(); dv = '0; end
        default: begin dv = rnd64() | 64'h1; dd = dv >> $urandom_range(1, 63); end
      endcase
      run_div($sformatf("rand_%0d", n), 1'($urandom()), dd, 1'($urandom()), dv, 0, 1'b0);
    end
  endtask

  task automatic test_reset_busy();
    int pulses;
    dividend_sign_in = 1'b0; dividend_in = 64'd99;
    divisor_sign_in  = 1'b0; divisor_in  = 64'd4;
    is_valid_in = 1'b1;
    @(posedge clk_in); #1;
    is_valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    checks++;
    if (is_ready_out !== 1'b1 || is_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_busy_handshake: ready=%b valid=%b expected 1 0",
                         is_ready_out, is_valid_out);
    end
    checks++;
    if (quotient_out !== '0 || remainder_out !== '0) begin
      errors++; $display("FAIL reset_busy_clear: q=%h r=%h expected 0 0",
                         quotient_out, remainder_out);
    end
    pulses = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk_in); #1;
      if (is_valid_out === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_busy_pulse: got %0d expected 0", pulses);
    end
    run_div("after_reset", 1'b1, 64'd99, 1'b0, 64'd4, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_held_valid();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
